// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Decode request, ALU drive and writeback bundle for alu_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_oper;
  logic [3:0]       req_func;
  logic [3:0]       req_cond;
  logic [WIDTH-1:0] req_dst;
  logic [WIDTH-1:0] req_src;
  logic [3:0]       req_wbaddr;

  logic [WIDTH-1:0] alu_dst;
  logic [WIDTH-1:0] alu_src;
  logic [3:0]       alu_oper;
  logic [3:0]       alu_func;
  logic [3:0]       alu_cond;
  logic [4:0]       alu_psrRead;
  logic [WIDTH-1:0] alu_result;
  logic [4:0]       alu_psrWrEn;
  logic [4:0]       alu_psrWrite;

  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [3:0]       wb_addr;
  logic             wb_we;

  logic [4:0]       psr;
  logic             busy;

  // Environment side: decode, combinational ALU and writeback port.
  modport master (
    output req_valid, req_oper, req_func, req_cond, req_dst, req_src, req_wbaddr,
    input  req_ready,
    input  alu_dst, alu_src, alu_oper, alu_func, alu_cond, alu_psrRead,
    output alu_result, alu_psrWrEn, alu_psrWrite,
    input  wb_valid, wb_data, wb_addr, wb_we,
    output wb_ready,
    input  psr, busy
  );

  // Controller side.
  modport slave (
    input  req_valid, req_oper, req_func, req_cond, req_dst, req_src, req_wbaddr,
    output req_ready,
    output alu_dst, alu_src, alu_oper, alu_func, alu_cond, alu_psrRead,
    input  alu_result, alu_psrWrEn, alu_psrWrite,
    output wb_valid, wb_data, wb_addr, wb_we,
    input  wb_ready,
    output psr, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Issue/PSR/writeback sequencer around a combinational 16-bit ALU.
//            Define ALU_MUL_STALL_EN to hold multiply MUL_CYCLES cycles in MULW.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 3
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULW = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [3:0] c_oper_alu = 4'b0000;
  localparam logic [3:0] c_oper_cmp = 4'b1011;
  localparam logic [3:0] c_func_cmp = 4'b1011;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_mul_cycles_range
    $error("alu_issue_ctrl: MUL_CYCLES must be within 1..15");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_dst;
  logic [WIDTH-1:0] r_src;
  logic [3:0]       r_oper;
  logic [3:0]       r_func;
  logic [3:0]       r_cond;
  logic [3:0]       r_wbaddr;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_wb_we;
  logic [4:0]       r_psr;
  logic             w_accept;
  logic             w_capture;
  logic             w_is_cmp;

  assign w_is_cmp = (r_oper == c_oper_cmp) ||
                    ((r_oper == c_oper_alu) && (r_func == c_func_cmp));

`ifdef ALU_MUL_STALL_EN
  localparam logic [3:0] c_func_mul = 4'b1110;
  localparam logic [3:0] c_cnt_init = 4'(MUL_CYCLES - 1);

  logic [3:0] r_cnt;
  logic       w_is_mul;
  logic       w_load_cnt;

  assign w_is_mul = (r_oper == c_oper_alu) && (r_func == c_func_mul);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_load_cnt) begin
      r_cnt <= c_cnt_init;
    end else if ((r_state == MULW) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
`ifdef ALU_MUL_STALL_EN
    w_load_cnt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_MUL_STALL_EN
        if (w_is_mul) begin
          w_load_cnt   = 1'b1;
          w_state_next = MULW;
        end else begin
          w_capture    = 1'b1;
          w_state_next = WB;
        end
`else
        w_capture    = 1'b1;
        w_state_next = WB;
`endif
      end
      MULW: begin
`ifdef ALU_MUL_STALL_EN
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = WB;
        end
`else
        w_state_next = IDLE;
`endif
      end
      WB: begin
        if (bus.wb_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // PSR is written only at the capture edge, so the next op reads it directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_dst     <= '0;
      r_src     <= '0;
      r_oper    <= 4'd0;
      r_func    <= 4'd0;
      r_cond    <= 4'd0;
      r_wbaddr  <= 4'd0;
      r_wb_data <= '0;
      r_wb_we   <= 1'b0;
      r_psr     <= 5'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_dst    <= bus.req_dst;
        r_src    <= bus.req_src;
        r_oper   <= bus.req_oper;
        r_func   <= bus.req_func;
        r_cond   <= bus.req_cond;
        r_wbaddr <= bus.req_wbaddr;
      end
      if (w_capture) begin
        r_wb_data <= bus.alu_result;
        r_wb_we   <= ~w_is_cmp;
        r_psr     <= (r_psr & ~bus.alu_psrWrEn) | (bus.alu_psrWrite & bus.alu_psrWrEn);
      end
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.wb_valid    = (r_state == WB);
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_addr     = r_wbaddr;
  assign bus.wb_we       = r_wb_we;
  assign bus.alu_dst     = r_dst;
  assign bus.alu_src     = r_src;
  assign bus.alu_oper    = r_oper;
  assign bus.alu_func    = r_func;
  assign bus.alu_cond    = r_cond;
  assign bus.alu_psrRead = r_psr;
  assign bus.psr         = r_psr;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Self-checking bench for alu_issue_ctrl with a stub ALU and PSR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
  localparam int WIDTH      = 16;
  localparam int MUL_CYCLES = 3;

  typedef struct packed {
    logic [15:0] r;
    logic [4:0]  en;
    logic [4:0]  wr;
  } alu_out_t;

  logic     clk = 1'b0;
  logic     reset;
  int       checks = 0;
  int       errors = 0;
  logic [4:0] m_psr;
  alu_out_t w_alu;

  alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus();

  alu_issue_ctrl #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synthetic ALU; flag bits are {C,L,F,Z,N}, disabled bits carry junk values.
  function automatic alu_out_t alu_f(input logic [3:0] op, input logic [3:0] fn,
                                     input logic [15:0] d, input logic [15:0] s,
                                     input logic [4:0] p);
    alu_out_t o;
    logic [16:0] w;
    logic [4:0]  f;
    w    = '0;
    f    = '0;
    o.en = '0;
    if (op == 4'b1011 || (op == 4'b0000 && fn == 4'b1011)) begin
      w    = {1'b0, d} - {1'b0, s};
      f[3] = ($signed(d) < $signed(s));
      o.en = 5'b11011;
    end else if (op == 4'b0000) begin
      case (fn)
        4'b0101: begin w = {1'b0, d} + {1'b0, s};                 o.en = 5'b10111; end
        4'b0111: begin w = {1'b0, d} + {1'b0, s} + {16'd0, p[4]}; o.en = 5'b10111; end
        4'b1001: begin w = {1'b0, d} - {1'b0, s};                 o.en = 5'b10111; end
        4'b0001: begin w = {1'b0, d & s};                         o.en = 5'b00011; end
        4'b1110: begin w = {1'b0, 16'(d * s)};                    o.en = 5'b00011; end
        default: begin w = {1'b0, d ^ s};                         o.en = 5'b00000; end
      endcase
    end else begin
      w    = {1'b0, d | s};
      o.en = 5'b00011;
    end
    o.r  = w[15:0];
    f[4] = w[16];
    f[2] = d[15] ^ s[15] ^ o.r[15] ^ w[16];
    f[1] = (o.r == 16'd0);
    f[0] = o.r[15];
    o.wr = (f & o.en) | (~o.en & (d[4:0] ^ s[4:0] ^ 5'h15));
    return o;
  endfunction

  always_comb begin
    w_alu            = alu_f(bus.alu_oper, bus.alu_func, bus.alu_dst, bus.alu_src, bus.alu_psrRead);
    bus.alu_result   = w_alu.r;
    bus.alu_psrWrEn  = w_alu.en;
    bus.alu_psrWrite = w_alu.wr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_req();
    bus.req_oper   = 4'($urandom);
    bus.req_func   = 4'($urandom);
    bus.req_cond   = 4'($urandom);
    bus.req_dst    = 16'($urandom);
    bus.req_src    = 16'($urandom);
    bus.req_wbaddr = 4'($urandom);
  endtask

  // One complete operation from IDLE back to IDLE, hold = cycles of wb_ready low.
  task automatic run_op(input logic [3:0] op, input logic [3:0] fn, input logic [15:0] d,
                        input logic [15:0] s, input logic [3:0] wa, input int hold);
    alu_out_t   e;
    logic       is_mul;
    logic       is_cmp;
    logic [3:0] cnd;
    int         lat;
    is_mul = (op == 4'b0000) && (fn == 4'b1110);
    is_cmp = (op == 4'b1011) || (op == 4'b0000 && fn == 4'b1011);
`ifdef ALU_MUL_STALL_EN
    lat = is_mul ? 1 + MUL_CYCLES : 1;
`else
    lat = 1;
`endif
    cnd = 4'($urandom);
    chk("idle_ready", 32'(bus.req_ready), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    bus.req_valid  = 1'b1;
    bus.req_oper   = op;
    bus.req_func   = fn;
    bus.req_cond   = cnd;
    bus.req_dst    = d;
    bus.req_src    = s;
    bus.req_wbaddr = wa;
    bus.wb_ready   = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble_req();
    chk("exec_busy", 32'(bus.busy), 1);
    chk("exec_ready", 32'(bus.req_ready), 0);
    chk("exec_wbvalid", 32'(bus.wb_valid), 0);
    chk("exec_dst", 32'(bus.alu_dst), 32'(d));
    chk("exec_src", 32'(bus.alu_src), 32'(s));
    chk("exec_oper", 32'({bus.alu_oper, bus.alu_func, bus.alu_cond}), 32'({op, fn, cnd}));
    chk("exec_psrread", 32'(bus.alu_psrRead), 32'(m_psr));
    e = alu_f(op, fn, d, s, m_psr);
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
      chk("stall_wbvalid", 32'(bus.wb_valid), 0);
      chk("stall_psr", 32'(bus.psr), 32'(m_psr));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (e.en[i]) m_psr[i] = e.wr[i];
    end
    chk("wb_valid", 32'(bus.wb_valid), 1);
    chk("wb_data", 32'(bus.wb_data), 32'(e.r));
    chk("wb_addr", 32'(bus.wb_addr), 32'(wa));
    chk("wb_we", 32'(bus.wb_we), 32'(!is_cmp));
    chk("wb_psr", 32'(bus.psr), 32'(m_psr));
    chk("wb_alu_dst", 32'(bus.alu_dst), 32'(d));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.wb_valid), 1);
      chk("bp_data", 32'(bus.wb_data), 32'(e.r));
      chk("bp_addr", 32'(bus.wb_addr), 32'(wa));
      chk("bp_ready", 32'(bus.req_ready), 0);
      chk("bp_psr", 32'(bus.psr), 32'(m_psr));
    end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid", 32'(bus.wb_valid), 0);
    chk("done_ready", 32'(bus.req_ready), 1);
  endtask

  // Accept an op, advance edges past accept, then assert reset between edges.
  task automatic reset_mid(input logic [3:0] op, input logic [3:0] fn, input int edges,
                           input logic exp_wbv);
    bus.req_valid  = 1'b1;
    bus.req_oper   = op;
    bus.req_func   = fn;
    bus.req_dst    = 16'h8001;
    bus.req_src    = 16'h8003;
    bus.req_wbaddr = 4'hA;
    bus.wb_ready   = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < edges; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 32'(bus.busy), 1);
    chk("pre_rst_wbvalid", 32'(bus.wb_valid), 32'(exp_wbv));
    #2 reset = 1'b1;
    #1;
    m_psr = 5'd0;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_wbvalid", 32'(bus.wb_valid), 0);
    chk("rst_psr", 32'(bus.psr), 0);
    chk("rst_wbdata", 32'({bus.wb_data, bus.wb_addr, 3'b000, bus.wb_we}), 0);
    chk("rst_alu", 32'({bus.alu_dst, bus.alu_oper, bus.alu_func, bus.alu_cond}), 0);
    reset = 1'b0;
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wbvalid", 32'(bus.wb_valid), 0);
    chk("post_rst_ready", 32'(bus.req_ready), 1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [3:0]  fn;
    logic [15:0] d;
    logic [15:0] s;
    int          hold;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b1;
    scramble_req();
    m_psr = 5'd0;
    @(posedge clk); #1;
    chk("reset_ready", 32'(bus.req_ready), 1);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_wbvalid", 32'(bus.wb_valid), 0);
    chk("reset_wbwe", 32'(bus.wb_we), 0);
    chk("reset_psr", 32'({bus.psr, bus.alu_psrRead}), 0);
    chk("reset_alu", 32'({bus.alu_dst, bus.alu_src}), 0);
    chk("reset_wb", 32'({bus.wb_data, bus.wb_addr}), 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'b0000, 4'b0101, 16'h0005, 16'h0003, 4'h1, 0);
    run_op(4'b1011, 4'b0000, 16'h1234, 16'h1234, 4'h2, 0);
    chk("cmp_z_flag", 32'(bus.psr[1]), 1);
    run_op(4'b0000, 4'b0101, 16'h00AA, 16'h0011, 4'h3, 5);
    run_op(4'b0000, 4'b1110, 16'h0004, 16'h0006, 4'h4, 0);
    chk("mul_result", 32'(bus.wb_data), 32'h0018);
    run_op(4'b0000, 4'b0101, 16'hFFFF, 16'h0002, 4'h5, 0);
    chk("add_carry", 32'(bus.psr[4]), 1);
    run_op(4'b0000, 4'b0111, 16'h0001, 16'h0001, 4'h6, 0);
    chk("addc_result", 32'(bus.wb_data), 32'h0003);

    for (int n = 0; n < 40; n++) begin
      d  = 16'($urandom);
      s  = 16'($urandom);
      op = 4'b0000;
      fn = 4'($urandom);
      case ($urandom_range(0, 7))
        0: fn = 4'b0101;
        1: fn = 4'b0111;
        2: fn = 4'b1001;
        3: fn = 4'b0001;
        4: fn = 4'b1110;
        5: op = 4'b1011;
        6: fn = 4'b1011;
        default: op = 4'($urandom_range(1, 10));
      endcase
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(op, fn, d, s, 4'($urandom), hold);
    end

    run_op(4'b0000, 4'b0101, 16'hFFFF, 16'h8001, 4'h7, 0);
`ifdef ALU_MUL_STALL_EN
    reset_mid(4'b0000, 4'b1110, 1, 1'b0);
`else
    reset_mid(4'b0000, 4'b1110, 0, 1'b0);
`endif
    run_op(4'b0000, 4'b1001, 16'h0001, 16'h0002, 4'h8, 0);
    reset_mid(4'b0000, 4'b0101, 1, 1'b1);
    run_op(4'b0000, 4'b0101, 16'h0005, 16'h0003, 4'h9, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
